shared_serial_comparator: RTL and testbench

- Two-requester arbiter and sequencer for a single 1-bit cascade magnitude-comparator cell (bit_comparator: inputs a, b, e, l, g; outputs E, L, G).
- Compares two WIDTH-bit unsigned operands serially, LSB first, one bit per clock. The cell's cascade inputs hold the registered result of the lower-order bits.
- Shares the one cell between two requesters with round-robin arbitration. Returns a tagged one-hot result (eq/lt/gt).

---
 rtl/shared_serial_comparator.sv | 179 +++++++++++++++++
 tb/tb_shared_serial_comparator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_serial_comparator.sv
// Round-robin sequencer that shares one 1-bit cascade magnitude-comparator cell
// between two requesters, comparing WIDTH-bit unsigned operands LSB first.

module bit_comparator (
  input  logic a_i,
  input  logic b_i,
  input  logic e_i,
  input  logic l_i,
  input  logic g_i,
  output logic e_o,
  output logic l_o,
  output logic g_o
);

  logic same;

  // A differing bit at this position overrides whatever the lower bits decided.
  assign same = ~(a_i ^ b_i);
  assign e_o  = same & e_i;
  assign l_o  = (~a_i & b_i) | (same & l_i);
  assign g_o  = (a_i & ~b_i) | (same & g_i);

endmodule

module shared_serial_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               e_q, e_d, l_q, l_d, g_q, g_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cur_id_q, cur_id_d;
  logic               last_id_q, last_id_d;
  logic               done_id_q, done_id_d;
  logic               eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic               pick1;
  logic               cell_e, cell_l, cell_g;

  bit_comparator u_cell (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .e_i (e_q),
    .l_i (l_q),
    .g_i (g_q),
    .e_o (cell_e),
    .l_o (cell_l),
    .g_o (cell_g)
  );

  // Next-state, grant arbitration and datapath updates.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    e_d       = e_q;
    l_d       = l_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
    cur_id_d  = cur_id_q;
    last_id_d = last_id_q;
    done_id_d = done_id_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    gt_d      = gt_q;
    pick1     = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie, the requester that was not served last wins.
          pick1     = req1 && (!req0 || !last_id_q);
          gnt0      = !pick1;
          gnt1      = pick1;
          a_sh_d    = pick1 ? a1 : a0;
          b_sh_d    = pick1 ? b1 : b0;
          e_d       = 1'b1;
          l_d       = 1'b0;
          g_d       = 1'b0;
          cnt_d     = '0;
          cur_id_d  = pick1;
          last_id_d = pick1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        e_d    = cell_e;
        l_d    = cell_l;
        g_d    = cell_g;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        done_id_d = cur_id_q;
        eq_d      = e_q;
        lt_d      = l_q;
        gt_d      = g_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      e_q       <= 1'b1;
      l_q       <= 1'b0;
      g_q       <= 1'b0;
      cnt_q     <= '0;
      cur_id_q  <= 1'b0;
      last_id_q <= 1'b1;
      done_id_q <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      e_q       <= e_d;
      l_q       <= l_d;
      g_q       <= g_d;
      cnt_q     <= cnt_d;
      cur_id_q  <= cur_id_d;
      last_id_q <= last_id_d;
      done_id_q <= done_id_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      gt_q      <= gt_d;
    end
  end

  assign done_id = done_id_q;
  assign eq      = eq_q;
  assign lt      = lt_q;
  assign gt      = gt_q;

endmodule

// File: tb/tb_shared_serial_comparator.sv
// Self-checking bench: an 8-bit instance for directed, arbitration, reset and random
// traffic, and a 4-bit instance swept over every operand pair.

module tb_shared_serial_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, done, done_id, eq, lt, gt;

  logic       req0_4, req1_4;
  logic [3:0] a0_4, b0_4, a1_4, b1_4;
  logic       gnt0_4, gnt1_4, busy_4, done_4, done_id_4, eq_4, lt_4, gt_4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int grant_cyc;
  logic last_id;
  logic last_win;

  shared_serial_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .eq(eq), .lt(lt), .gt(gt)
  );

  shared_serial_comparator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0(req0_4), .a0(a0_4), .b0(b0_4),
    .req1(req1_4), .a1(a1_4), .b1(b1_4),
    .gnt0(gnt0_4), .gnt1(gnt1_4), .busy(busy_4), .done(done_4), .done_id(done_id_4),
    .eq(eq_4), .lt(lt_4), .gt(gt_4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {eq,lt,gt} straight from integer comparison.
  function automatic logic [2:0] ref_flags(input int unsigned a, input int unsigned b);
    if (a == b) return 3'b100;
    if (a < b)  return 3'b010;
    return 3'b001;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    last_id = 1'b1;
    #1;
  endtask

  // Waits for a grant on the 8-bit instance and checks the whole transaction.
  task automatic serve8(input logic drop_winner);
    int   t_wait;
    logic exp_win;
    logic [7:0] ea, eb;
    exp_win = (req0 && req1) ? ~last_id : (req0 ? 1'b0 : 1'b1);
    t_wait = 0;
    while (!(gnt0 || gnt1) && t_wait < 40) begin
      @(negedge clk); #1;
      t_wait++;
    end
    if (!(gnt0 || gnt1)) begin
      check("grant_seen", 32'(gnt0 | gnt1), 32'd1);
      return;
    end
    check("gnt0", 32'(gnt0), 32'(exp_win == 1'b0));
    check("gnt1", 32'(gnt1), 32'(exp_win == 1'b1));
    grant_cyc = cyc;
    last_id   = exp_win;
    last_win  = exp_win;
    ea = exp_win ? a1 : a0;
    eb = exp_win ? b1 : b0;
    @(negedge clk);
    if (drop_winner) begin
      if (exp_win) req1 = 1'b0;
      else         req0 = 1'b0;
    end
    #1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) begin
        @(negedge clk); #1;
      end
      check("run_busy", 32'(busy), 32'd1);
      check("run_gnt", 32'({gnt0, gnt1}), 32'd0);
      check("run_done", 32'(done), 32'd0);
    end
    @(negedge clk); #1;
    check("fin_done", 32'(done), 32'd1);
    check("fin_busy", 32'(busy), 32'd0);
    check("fin_gnt", 32'({gnt0, gnt1}), 32'd0);
    @(negedge clk); #1;
    check("post_done", 32'(done), 32'd0);
    check("done_id", 32'(done_id), 32'(exp_win));
    check("flags", 32'({eq, lt, gt}), 32'(ref_flags(32'(ea), 32'(eb))));
  endtask

  initial begin
    logic [1:0] r;
    logic [2:0] ef;
    int t_wait;
    int prev_cyc;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    req0_4 = 1'b0; req1_4 = 1'b0; a0_4 = '0; b0_4 = '0; a1_4 = '0; b1_4 = '0;
    last_id = 1'b1;

    // Reset, then idle with no requests.
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      check("idle8", 32'({gnt0, gnt1, busy, done, done_id, eq, lt, gt}), 32'd0);
      check("idle4", 32'({gnt0_4, gnt1_4, busy_4, done_4, done_id_4, eq_4, lt_4, gt_4}), 32'd0);
      @(negedge clk); #1;
    end

    // Directed single compares on requester 0.
    req0 = 1'b1; a0 = 8'h5A; b0 = 8'h5A; #1; serve8(1'b1);
    req0 = 1'b1; a0 = 8'h80; b0 = 8'h7F; #1; serve8(1'b1);
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h02; #1; serve8(1'b1);

    // Both held continuously: grants alternate 0,1,0,1 every 10 cycles.
    do_reset(1);
    req0 = 1'b1; a0 = 8'd3; b0 = 8'd9;
    req1 = 1'b1; a1 = 8'd9; b1 = 8'd3;
    #1;
    prev_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      serve8(1'b0);
      check("arb_order", 32'(last_win), 32'(i % 2));
      if (i > 0) check("arb_spacing", 32'(grant_cyc - prev_cyc), 32'd10);
      prev_cyc = grant_cyc;
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset four cycles after a grant aborts the operation.
    @(negedge clk);
    req0 = 1'b1; a0 = 8'h11; b0 = 8'h22; #1;
    t_wait = 0;
    while (!gnt0 && t_wait < 40) begin
      @(negedge clk); #1;
      t_wait++;
    end
    check("abort_grant", 32'(gnt0), 32'd1);
    @(negedge clk); req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_id = 1'b1;
    #1;
    for (int i = 0; i < 15; i++) begin
      check("abort_quiet", 32'({busy, done, eq, lt, gt}), 32'd0);
      @(negedge clk); #1;
    end
    req0 = 1'b1; a0 = 8'h40; b0 = 8'h41;
    req1 = 1'b1; a1 = 8'hC3; b1 = 8'h3C;
    #1;
    serve8(1'b1);
    check("abort_tie_id", 32'(last_win), 32'd0);
    serve8(1'b1);
    req1 = 1'b1; a1 = 8'h77; b1 = 8'h77; #1;
    serve8(1'b1);
    check("abort_req1_id", 32'(last_win), 32'd1);

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      r = 2'($urandom_range(1, 3));
      req0 = r[0]; req1 = r[1];
      a0 = 8'($urandom); b0 = ($urandom_range(0, 3) == 0) ? a0 : 8'($urandom);
      a1 = 8'($urandom); b1 = ($urandom_range(0, 3) == 0) ? a1 : 8'($urandom);
      #1;
      serve8(1'b1);
      req0 = 1'b0; req1 = 1'b0;
    end

    // Exhaustive 4-bit sweep through requester 1.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        req1_4 = 1'b1; a1_4 = 4'(a); b1_4 = 4'(b); #1;
        t_wait = 0;
        while (!gnt1_4 && t_wait < 20) begin
          @(negedge clk); #1;
          t_wait++;
        end
        check("w4_gnt1", 32'(gnt1_4), 32'd1);
        check("w4_gnt0", 32'(gnt0_4), 32'd0);
        @(negedge clk); req1_4 = 1'b0; #1;
        for (int k = 1; k <= 4; k++) begin
          if (k > 1) begin
            @(negedge clk); #1;
          end
          check("w4_busy", 32'(busy_4), 32'd1);
        end
        @(negedge clk); #1;
        check("w4_done", 32'(done_4), 32'd1);
        @(negedge clk); #1;
        ef = ref_flags(32'(a), 32'(b));
        check("w4_flags", 32'({eq_4, lt_4, gt_4}), 32'(ef));
        check("w4_onehot", 32'(32'(eq_4) + 32'(lt_4) + 32'(gt_4)), 32'd1);
        check("w4_done_id", 32'(done_id_4), 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
